// File: rtl/rename_reg_file_pkg.sv
// Shared defaults and the per-register rename entry for the rename register file.
// The entry tag width is DEF_TAG_W; override it together with the TAG_W parameters.
package rename_reg_file_pkg;

  localparam int unsigned DEF_XLEN  = 32;
  localparam int unsigned DEF_NREG  = 32;
  localparam int unsigned DEF_TAG_W = 4;
  localparam int unsigned DEF_NRP   = 2;
  localparam int unsigned DEF_NCM   = 2;
  localparam int unsigned DEF_NCK   = 4;

  typedef struct packed {
    logic                 busy;
    logic [DEF_TAG_W-1:0] tag;
  } ren_entry_t;

  // True when a commit carrying tag t is the latest producer of entry e
  function automatic logic tag_hit(input ren_entry_t e, input logic [DEF_TAG_W-1:0] t);
    return e.busy && (e.tag == t);
  endfunction

endpackage

// File: rtl/rename_reg_file_if.sv
// Pipeline-facing bundle of the rename register file: commit, issue, read and checkpoint ports.
interface rename_reg_file_if
  import rename_reg_file_pkg::*;
#(
  parameter int unsigned XLEN  = DEF_XLEN,
  parameter int unsigned NREG  = DEF_NREG,
  parameter int unsigned TAG_W = DEF_TAG_W,
  parameter int unsigned NRP   = DEF_NRP,
  parameter int unsigned NCM   = DEF_NCM,
  parameter int unsigned NCK   = DEF_NCK
);

  localparam int unsigned AW = $clog2(NREG);
  localparam int unsigned CW = $clog2(NCK);

  logic                  rdy;
  logic                  flush;
  logic [NCM-1:0]        cm_vld;
  logic [NCM*AW-1:0]     cm_rd;
  logic [NCM*XLEN-1:0]   cm_val;
  logic [NCM*TAG_W-1:0]  cm_tag;
  logic                  is_vld;
  logic [AW-1:0]         is_rd;
  logic [TAG_W-1:0]      is_tag;
  logic [NRP*AW-1:0]     rd_addr;
  logic [NRP*XLEN-1:0]   rd_val;
  logic [NRP-1:0]        rd_busy;
  logic [NRP*TAG_W-1:0]  rd_tag;
  logic                  ck_save;
  logic [CW-1:0]         ck_id;
  logic                  ck_full;
  logic                  ck_rst_vld;
  logic [CW-1:0]         ck_rst_id;
  logic [NCK-1:0]        ck_kill;
  logic                  ck_rel_vld;
  logic [CW-1:0]         ck_rel_id;
  logic                  ck_ovf;

  modport master (
    output rdy, flush, cm_vld, cm_rd, cm_val, cm_tag, is_vld, is_rd, is_tag, rd_addr,
           ck_save, ck_rst_vld, ck_rst_id, ck_kill, ck_rel_vld, ck_rel_id,
    input  rd_val, rd_busy, rd_tag, ck_id, ck_full, ck_ovf
  );

  modport slave (
    input  rdy, flush, cm_vld, cm_rd, cm_val, cm_tag, is_vld, is_rd, is_tag, rd_addr,
           ck_save, ck_rst_vld, ck_rst_id, ck_kill, ck_rel_vld, ck_rel_id,
    output rd_val, rd_busy, rd_tag, ck_id, ck_full, ck_ovf
  );

endinterface

// File: rtl/rename_ckpt_bank.sv
// Branch checkpoint storage: NCK busy/tag snapshots with valid bits, commit-time
// clearing of stale producers, and a lowest-free-slot encoder.
module rename_ckpt_bank
  import rename_reg_file_pkg::*;
#(
  parameter int unsigned NREG  = DEF_NREG,
  parameter int unsigned TAG_W = DEF_TAG_W,
  parameter int unsigned NCM   = DEF_NCM,
  parameter int unsigned NCK   = DEF_NCK,
  parameter int unsigned AW    = $clog2(NREG),
  parameter int unsigned CW    = $clog2(NCK)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       flush,
  input  logic [NCM-1:0]             cm_vld,
  input  logic [NCM*AW-1:0]          cm_rd,
  input  logic [NCM*TAG_W-1:0]       cm_tag,
  input  ren_entry_t [NREG-1:0]      cur_ent,
  input  logic                       save,
  input  logic                       rst_vld,
  input  logic [CW-1:0]              rst_id,
  input  logic [NCK-1:0]             kill,
  input  logic                       rel_vld,
  input  logic [CW-1:0]              rel_id,
  output ren_entry_t [NREG-1:0]      rst_ent,
  output logic [CW-1:0]              ck_id,
  output logic                       ck_full,
  output logic                       ovf
);

  ren_entry_t [NCK-1:0][NREG-1:0] snap_q, snap_cm, snap_d;
  logic [NCK-1:0]                 vld_q, vld_d;
  logic                           ovf_q, ovf_d;

  // Retire matching producers inside every snapshot, same rule as the live array
  always_comb begin
    snap_cm = snap_q;
    for (int s = 0; s < NCK; s++) begin
      for (int r = 1; r < NREG; r++) begin
        for (int k = 0; k < NCM; k++) begin
          if (cm_vld[k] && (cm_rd[k*AW +: AW] == AW'(r)) &&
              tag_hit(snap_q[s][r], DEF_TAG_W'(cm_tag[k*TAG_W +: TAG_W])))
            snap_cm[s][r] = '0;
        end
      end
    end
  end

  always_comb begin
    ck_id   = '0;
    ck_full = &vld_q;
    for (int s = NCK - 1; s >= 0; s--) begin
      if (!vld_q[s]) ck_id = CW'(s);
    end
  end

  assign rst_ent = snap_cm[rst_id];
  assign ovf     = ovf_q;

  always_comb begin
    vld_d  = vld_q;
    snap_d = snap_cm;
    ovf_d  = ovf_q;
    if (rst_vld) begin
      vld_d[rst_id] = 1'b0;
      vld_d         = vld_d & ~kill;
    end
    if (rel_vld) vld_d[rel_id] = 1'b0;
    if (save) begin
      if (ck_full) begin
        ovf_d = 1'b1;
      end else begin
        vld_d[ck_id]  = 1'b1;
        snap_d[ck_id] = cur_ent;
      end
    end
    if (flush) vld_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_q <= '0;
      vld_q  <= '0;
      ovf_q  <= 1'b0;
    end else if (en) begin
      snap_q <= snap_d;
      vld_q  <= vld_d;
      ovf_q  <= ovf_d;
    end
  end

endmodule

// File: rtl/rename_reg_file.sv
// Architectural register file with rename busy/tag tracking, commit bypass on reads
// and branch checkpoint save/restore.
module rename_reg_file
  import rename_reg_file_pkg::*;
#(
  parameter int unsigned XLEN  = DEF_XLEN,
  parameter int unsigned NREG  = DEF_NREG,
  parameter int unsigned TAG_W = DEF_TAG_W,
  parameter int unsigned NRP   = DEF_NRP,
  parameter int unsigned NCM   = DEF_NCM,
  parameter int unsigned NCK   = DEF_NCK
) (
  input  logic             clk,
  input  logic             rst,
  rename_reg_file_if.slave bus
);

  localparam int unsigned AW = $clog2(NREG);
  localparam int unsigned CW = $clog2(NCK);

  logic [NREG-1:0][XLEN-1:0] val_q, wr_val;
  logic [NREG-1:0]           wr_en;
  ren_entry_t [NREG-1:0]     ent_q, ent_cm, ent_d, ent_rst;

  // Commit decode: youngest port supplies the value, any matching port retires the producer
  always_comb begin
    wr_en  = '0;
    wr_val = '0;
    ent_cm = ent_q;
    for (int r = 1; r < NREG; r++) begin
      for (int k = 0; k < NCM; k++) begin
        if (bus.cm_vld[k] && (bus.cm_rd[k*AW +: AW] == AW'(r))) begin
          wr_en[r]  = 1'b1;
          wr_val[r] = bus.cm_val[k*XLEN +: XLEN];
          if (tag_hit(ent_q[r], DEF_TAG_W'(bus.cm_tag[k*TAG_W +: TAG_W])))
            ent_cm[r] = '0;
        end
      end
    end
  end

  // Busy/tag next state: flush > restore > issue > commit clear
  always_comb begin
    ent_d = ent_cm;
    if (bus.is_vld && (bus.is_rd != '0))
      ent_d[bus.is_rd] = '{busy: 1'b1, tag: DEF_TAG_W'(bus.is_tag)};
    if (bus.ck_rst_vld) ent_d = ent_rst;
    if (bus.flush) ent_d = '0;
    ent_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q <= '0;
      ent_q <= '0;
    end else if (bus.rdy) begin
      ent_q <= ent_d;
      for (int r = 1; r < NREG; r++) begin
        if (wr_en[r]) val_q[r] <= wr_val[r];
      end
    end
  end

  // Read ports see retiring producers this cycle but not same-cycle issue
  always_comb begin
    logic [AW-1:0]   a;
    logic            hit;
    logic [XLEN-1:0] hv;
    a           = '0;
    hit         = 1'b0;
    hv          = '0;
    bus.rd_val  = '0;
    bus.rd_busy = '0;
    bus.rd_tag  = '0;
    for (int p = 0; p < NRP; p++) begin
      a   = bus.rd_addr[p*AW +: AW];
      hit = 1'b0;
      hv  = '0;
      for (int k = 0; k < NCM; k++) begin
        if (bus.cm_vld[k] && (a != '0) && (bus.cm_rd[k*AW +: AW] == a) &&
            tag_hit(ent_q[a], DEF_TAG_W'(bus.cm_tag[k*TAG_W +: TAG_W]))) begin
          hit = 1'b1;
          hv  = bus.cm_val[k*XLEN +: XLEN];
        end
      end
      if (hit) begin
        bus.rd_val[p*XLEN +: XLEN]   = hv;
        bus.rd_busy[p]               = 1'b0;
        bus.rd_tag[p*TAG_W +: TAG_W] = '0;
      end else begin
        bus.rd_val[p*XLEN +: XLEN]   = val_q[a];
        bus.rd_busy[p]               = ent_q[a].busy;
        bus.rd_tag[p*TAG_W +: TAG_W] = TAG_W'(ent_q[a].tag);
      end
    end
  end

  rename_ckpt_bank #(
    .NREG  (NREG),
    .TAG_W (TAG_W),
    .NCM   (NCM),
    .NCK   (NCK),
    .AW    (AW),
    .CW    (CW)
  ) u_ckpt (
    .clk     (clk),
    .rst     (rst),
    .en      (bus.rdy),
    .flush   (bus.flush),
    .cm_vld  (bus.cm_vld),
    .cm_rd   (bus.cm_rd),
    .cm_tag  (bus.cm_tag),
    .cur_ent (ent_cm),
    .save    (bus.ck_save),
    .rst_vld (bus.ck_rst_vld),
    .rst_id  (bus.ck_rst_id),
    .kill    (bus.ck_kill),
    .rel_vld (bus.ck_rel_vld),
    .rel_id  (bus.ck_rel_id),
    .rst_ent (ent_rst),
    .ck_id   (bus.ck_id),
    .ck_full (bus.ck_full),
    .ovf     (bus.ck_ovf)
  );

endmodule

// File: tb/tb_rename_reg_file.sv
// Directed bench for rename_reg_file: commit bypass, rename overwrite, multi-port
// commits, checkpoint save/restore/release/overflow, flush, rdy freeze and reset.
module tb_rename_reg_file;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  rename_reg_file_if bus ();

  rename_reg_file dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
  endtask

  task automatic idle();
    rst            = 1'b0;
    bus.rdy        = 1'b1;
    bus.flush      = 1'b0;
    bus.cm_vld     = '0;
    bus.cm_rd      = '0;
    bus.cm_val     = '0;
    bus.cm_tag     = '0;
    bus.is_vld     = 1'b0;
    bus.is_rd      = '0;
    bus.is_tag     = '0;
    bus.rd_addr    = '0;
    bus.ck_save    = 1'b0;
    bus.ck_rst_vld = 1'b0;
    bus.ck_rst_id  = '0;
    bus.ck_kill    = '0;
    bus.ck_rel_vld = 1'b0;
    bus.ck_rel_id  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic issue(input int r, input int t);
    bus.is_vld = 1'b1;
    bus.is_rd  = 5'(r);
    bus.is_tag = 4'(t);
  endtask

  task automatic cmt(input int k, input int r, input int t, input logic [31:0] v);
    bus.cm_vld[k]          = 1'b1;
    bus.cm_rd[k*5 +: 5]    = 5'(r);
    bus.cm_tag[k*4 +: 4]   = 4'(t);
    bus.cm_val[k*32 +: 32] = v;
  endtask

  // Point read port p at register r and check value/busy/tag
  task automatic rdc(input string name, input int p, input int r,
                     input logic [31:0] v, input logic b, input logic [3:0] t);
    bus.rd_addr[p*5 +: 5] = 5'(r);
    #1;
    chk({name, ".val"},  64'(bus.rd_val[p*32 +: 32]), 64'(v));
    chk({name, ".busy"}, 64'(bus.rd_busy[p]),         64'(b));
    chk({name, ".tag"},  64'(bus.rd_tag[p*4 +: 4]),   64'(t));
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    idle();

    // Reset state
    chk("rst.ck_id",   64'(bus.ck_id),   64'd0);
    chk("rst.ck_full", 64'(bus.ck_full), 64'd0);
    chk("rst.ck_ovf",  64'(bus.ck_ovf),  64'd0);
    rdc("rst.x5", 0, 5, 32'h0, 1'b0, 4'd0);

    // Issue then commit with same-cycle bypass
    issue(5, 3); tick();
    rdc("iss.x5", 0, 5, 32'h0, 1'b1, 4'd3);
    cmt(0, 5, 3, 32'hDEAD);
    rdc("byp.x5", 0, 5, 32'hDEAD, 1'b0, 4'd0);
    tick();
    rdc("cm.x5", 0, 5, 32'hDEAD, 1'b0, 4'd0);

    // Older commit does not clear a younger rename
    issue(5, 3); tick();
    issue(5, 7); tick();
    cmt(0, 5, 3, 32'h11);
    rdc("old.byp", 1, 5, 32'hDEAD, 1'b1, 4'd7);
    tick();
    rdc("old.x5", 1, 5, 32'h11, 1'b1, 4'd7);

    // Two commits to x9, younger port matches
    issue(9, 4); tick();
    cmt(0, 9, 2, 32'hA); cmt(1, 9, 4, 32'hB);
    rdc("dual.byp", 0, 9, 32'hB, 1'b0, 4'd0);
    tick();
    rdc("dual.x9", 0, 9, 32'hB, 1'b0, 4'd0);

    // Older port matches: bypass from it, array takes youngest value
    issue(9, 6); tick();
    cmt(0, 9, 6, 32'hC); cmt(1, 9, 1, 32'hD);
    rdc("dual2.byp", 0, 9, 32'hC, 1'b0, 4'd0);
    tick();
    rdc("dual2.x9", 0, 9, 32'hD, 1'b0, 4'd0);

    // Checkpoint save, younger rename, commit clears snapshot, restore drops issue
    issue(3, 1); tick();
    chk("sv.ck_id0", 64'(bus.ck_id), 64'd0);
    bus.ck_save = 1'b1; tick();
    chk("sv.ck_id1", 64'(bus.ck_id), 64'd1);
    issue(3, 2); tick();
    cmt(0, 3, 1, 32'h33); tick();
    rdc("pre.x3", 0, 3, 32'h33, 1'b1, 4'd2);
    bus.ck_rst_vld = 1'b1; bus.ck_rst_id = 2'd0; issue(3, 9); tick();
    rdc("rs.x3", 0, 3, 32'h33, 1'b0, 4'd0);
    chk("rs.ck_id", 64'(bus.ck_id), 64'd0);

    // Fill all slots, overflow, release
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fill.id%0d", i), 64'(bus.ck_id), 64'(i));
      bus.ck_save = 1'b1; tick();
    end
    chk("full.ck_full", 64'(bus.ck_full), 64'd1);
    chk("full.ck_ovf0", 64'(bus.ck_ovf),  64'd0);
    bus.ck_save = 1'b1; tick();
    chk("ovf.ck_ovf",  64'(bus.ck_ovf),  64'd1);
    chk("ovf.ck_full", 64'(bus.ck_full), 64'd1);
    bus.ck_rel_vld = 1'b1; bus.ck_rel_id = 2'd2; tick();
    chk("rel2.ck_id",   64'(bus.ck_id),   64'd2);
    chk("rel2.ck_full", 64'(bus.ck_full), 64'd0);
    bus.ck_rel_vld = 1'b1; bus.ck_rel_id = 2'd2; tick();
    chk("rel2x.ck_id", 64'(bus.ck_id), 64'd2);
    bus.ck_rel_vld = 1'b1; bus.ck_rel_id = 2'd1; tick();
    chk("rel1.ck_id", 64'(bus.ck_id), 64'd1);

    // Flush beats same-cycle issue and empties the bank
    bus.flush = 1'b1; issue(4, 5); tick();
    rdc("fl.x4", 0, 4, 32'h0, 1'b0, 4'd0);
    rdc("fl.x5", 1, 5, 32'h11, 1'b0, 4'd0);
    chk("fl.ck_id",   64'(bus.ck_id),   64'd0);
    chk("fl.ck_full", 64'(bus.ck_full), 64'd0);
    chk("fl.ck_ovf",  64'(bus.ck_ovf),  64'd1);

    // x0 is never written or renamed
    issue(0, 3); cmt(0, 0, 0, 32'hFF); tick();
    rdc("x0", 0, 0, 32'h0, 1'b0, 4'd0);

    // rdy low freezes state while reads still track inputs
    issue(6, 2); tick();
    bus.rdy = 1'b0; cmt(0, 6, 2, 32'h66); bus.ck_save = 1'b1;
    rdc("frz.byp", 0, 6, 32'h66, 1'b0, 4'd0);
    tick();
    rdc("frz.x6", 0, 6, 32'h0, 1'b1, 4'd2);
    chk("frz.ck_id", 64'(bus.ck_id), 64'd0);

    // Reset mid-sequence with rdy low
    bus.ck_save = 1'b1; tick();
    chk("pre.ck_id", 64'(bus.ck_id), 64'd1);
    rst = 1'b1; bus.rdy = 1'b0; issue(7, 1);
    @(posedge clk); #1; idle();
    rdc("rst2.x6", 0, 6, 32'h0, 1'b0, 4'd0);
    rdc("rst2.x9", 1, 9, 32'h0, 1'b0, 4'd0);
    rdc("rst2.x7", 0, 7, 32'h0, 1'b0, 4'd0);
    chk("rst2.ck_id",   64'(bus.ck_id),   64'd0);
    chk("rst2.ck_full", 64'(bus.ck_full), 64'd0);
    chk("rst2.ck_ovf",  64'(bus.ck_ovf),  64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
